alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
// Drives the combinational ALU as its initiator: accepts one R-type op (funct + two operands)
// per valid/ready handshake, decodes funct to the 3-bit ALU control code, presents operands,
// captures the ALU result into a register and holds it on a valid/ready output until consumed.
// Sits in the execute stage between register-file read and write-back.
// PARAMETERS
// DATA_W   32  operand/result width; must equal the ALU width
// FUNCT_W   6  width of the funct field
// CNT_W    16  width of the retired-op counter
// PORTS
// clk          in   1        clock, rising edge
// rst_n        in   1        reset, asynchronous, active-low
// in_valid     in   1        op request valid
// in_ready     out  1        ctrl can accept an op
// in_funct     in   FUNCT_W  R-type funct field
// in_rs        in   DATA_W   operand rs
// in_rt        in   DATA_W   operand rt
// alu_dr1      out  DATA_W   to ALU DR1
// alu_dr2      out  DATA_W   to ALU DR2
// alu_ctrl     out  3        to ALU ALUControl
// alu_result   in   DATA_W   from ALU ALUOutput (combinational)
// out_valid    out  1        result valid
// out_ready    in   1        consumer accepts result
// out_result   out  DATA_W   registered result
// out_zero     out  1        out_result == 0 (ALU zero output is not used)
// out_illegal  out  1        funct was not a supported code; out_result = 0
// op_count     out  CNT_W    count of results consumed (wraps)
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; out_result=0; out_zero=1;
//   out_illegal=0; op_count=0; alu_dr1=alu_dr2=0; alu_ctrl=3'b001.
// - FSM IDLE -> EXEC -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready, register funct/rs/rt, decode, go EXEC.
//   EXEC: in_ready=0; ALU driven from registers; at edge capture alu_result (or 0 if illegal)
//         into out_result, compute out_zero, set out_illegal, go DONE.
//   DONE: out_valid=1, outputs stable. On out_ready: out_valid drops next cycle, op_count+1,
//         go IDLE. No new op accepted in the DONE->IDLE cycle.
// - Latency: accept edge to out_valid high = 2 cycles; throughput 1 op / 3 cycles min.
// - Decode (funct -> alu_ctrl; dr1, dr2):
//   0x20/0x21 add/addu -> 001; rs, rt      0x22/0x23 sub/subu -> 010; rs, rt
//   0x24 and -> 100; 0x25 or -> 101; 0x26 xor -> 110; 0x27 nor -> 111; all rs, rt
//   0x2B sltu -> 011; dr1=rt, dr2=rs (ALU computes dr1>dr2 unsigned, so swap gives rs<rt)
//   0x2A slt  -> 011; dr1=rt^MSB, dr2=rs^MSB (invert bit DATA_W-1 to map signed onto unsigned)
//   any other funct: illegal; alu_ctrl=001, operands 0, out_result=0, out_illegal=1.
// - alu_ctrl is never 3'b000 (the ALU has no 000 case and must not be left holding state).
//   Outside EXEC alu_ctrl=001 and operands hold last registered values.
// - Arithmetic wraps modulo 2^DATA_W; no overflow trap (add/addu identical here).
// - op_count wraps from 2^CNT_W-1 to 0; counts illegal ops too.
// - in_valid ignored while not IDLE; in_* need only be stable during the accept cycle.
// - out_ready while out_valid=0 has no effect.
// - Reset asserted in EXEC or DONE: op discarded, not counted; all outputs at reset values.
// STRUCTURE
// - Shared package alu_pkg: ALU control codes (ALU_ADD=3'b001 .. ALU_NOR=3'b111), funct
//   constants (FUNCT_ADD..FUNCT_SLTU), FSM state enum.
// - One sub-module: alu_funct_decode (combinational funct -> ctrl, swap, signed_bias, illegal).
// - ALU itself is instantiated by the parent; this block only drives/reads its ports.
// TESTING (bench instantiates this block with the real ALU)
// - add: funct=0x20, rs=5, rt=7 -> out_result=12, out_zero=0, out_valid 2 cycles after accept.
// - slt signed: funct=0x2A, rs=0xFFFFFFFF(-1), rt=1 -> 1; sltu same operands -> 0.
// - sub to zero: funct=0x22, rs=rt=0x1234 -> out_result=0, out_zero=1; nor 0,0 -> 0xFFFFFFFF.
// - illegal: funct=0x08 -> out_illegal=1, out_result=0, alu_ctrl never 000; op_count increments.
// - backpressure: hold out_ready=0 10 cycles -> out_valid/out_result stable, in_ready=0 throughout.
// - reset in EXEC: drop rst_n mid-op -> outputs at reset values immediately, op_count unchanged=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: ALU control codes,
// R-type funct codes and the issue FSM state type.
package alu_pkg;

  // ALU control codes; 3'b000 is deliberately absent, the ALU has no such case
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_NOR = 3'b111;

  // R-type funct field values understood by the controller
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational funct decoder: ALU control code, operand swap, signed bias
// (MSB flip so an unsigned compare orders signed values) and illegal flag.
module alu_funct_decode
  import alu_pkg::*;
#(
  parameter int FUNCT_W = 6
) (
  input  logic [FUNCT_W-1:0] funct,
  output logic [2:0]         ctrl,
  output logic               swap,
  output logic               signed_bias,
  output logic               illegal
);

  // Map funct onto the ALU control code and operand steering
  always_comb begin
    ctrl        = ALU_ADD;
    swap        = 1'b0;
    signed_bias = 1'b0;
    illegal     = 1'b0;
    case (funct)
      FUNCT_ADD, FUNCT_ADDU: ctrl = ALU_ADD;
      FUNCT_SUB, FUNCT_SUBU: ctrl = ALU_SUB;
      FUNCT_AND:             ctrl = ALU_AND;
      FUNCT_OR:              ctrl = ALU_OR;
      FUNCT_XOR:             ctrl = ALU_XOR;
      FUNCT_NOR:             ctrl = ALU_NOR;
      // ALU computes dr1 > dr2 unsigned, so swapping yields rs < rt
      FUNCT_SLTU: begin
        ctrl = ALU_SLT;
        swap = 1'b1;
      end
      FUNCT_SLT: begin
        ctrl        = ALU_SLT;
        swap        = 1'b1;
        signed_bias = 1'b1;
      end
      default: begin
        ctrl    = ALU_ADD;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue controller: accepts one R-type op per handshake, drives
// the external combinational ALU from registers, captures and holds the result.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int FUNCT_W = 6,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FUNCT_W-1:0] in_funct,
  input  logic [DATA_W-1:0]  in_rs,
  input  logic [DATA_W-1:0]  in_rt,
  output logic [DATA_W-1:0]  alu_dr1,
  output logic [DATA_W-1:0]  alu_dr2,
  output logic [2:0]         alu_ctrl,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_result,
  output logic               out_zero,
  output logic               out_illegal,
  output logic [CNT_W-1:0]   op_count
);

  localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] ZERO_W   = {DATA_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]        dec_ctrl_s;
  logic              dec_swap_s;
  logic              dec_bias_s;
  logic              dec_illegal_s;
  logic [DATA_W-1:0] op1_s;
  logic [DATA_W-1:0] op2_s;

  state_t            state_r;
  logic              illegal_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [DATA_W-1:0] out_result_r;
  logic              out_zero_r;
  logic              out_illegal_r;
  logic [CNT_W-1:0]  op_count_r;
  logic [DATA_W-1:0] alu_dr1_r;
  logic [DATA_W-1:0] alu_dr2_r;
  logic [2:0]        alu_ctrl_r;

  alu_funct_decode #(
    .FUNCT_W(FUNCT_W)
  ) u_decode (
    .funct      (in_funct),
    .ctrl       (dec_ctrl_s),
    .swap       (dec_swap_s),
    .signed_bias(dec_bias_s),
    .illegal    (dec_illegal_s)
  );

  // Steer incoming operands into ALU order; illegal ops present zeros
  always_comb begin
    op1_s = in_rs;
    op2_s = in_rt;
    if (dec_illegal_s) begin
      op1_s = ZERO_W;
      op2_s = ZERO_W;
    end else if (dec_swap_s) begin
      op1_s = in_rt ^ (dec_bias_s ? MSB_MASK : ZERO_W);
      op2_s = in_rs ^ (dec_bias_s ? MSB_MASK : ZERO_W);
    end else begin
      op1_s = in_rs;
      op2_s = in_rt;
    end
  end

  // Issue FSM with all outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      illegal_r     <= 1'b0;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      out_result_r  <= ZERO_W;
      out_zero_r    <= 1'b1;
      out_illegal_r <= 1'b0;
      op_count_r    <= {CNT_W{1'b0}};
      alu_dr1_r     <= ZERO_W;
      alu_dr2_r     <= ZERO_W;
      alu_ctrl_r    <= ALU_ADD;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            alu_dr1_r  <= op1_s;
            alu_dr2_r  <= op2_s;
            alu_ctrl_r <= dec_ctrl_s;
            illegal_r  <= dec_illegal_s;
            in_ready_r <= 1'b0;
            state_r    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          out_result_r  <= illegal_r ? ZERO_W : alu_result;
          out_zero_r    <= illegal_r || (alu_result == ZERO_W);
          out_illegal_r <= illegal_r;
          out_valid_r   <= 1'b1;
          alu_ctrl_r    <= ALU_ADD;
          state_r       <= ST_DONE;
        end
        ST_DONE: begin
          // ready rises only after the consume edge, so no op is taken in that cycle
          if (out_ready) begin
            out_valid_r <= 1'b0;
            op_count_r  <= op_count_r + CNT_ONE;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          alu_ctrl_r  <= ALU_ADD;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_r;
  assign out_valid   = out_valid_r;
  assign out_result  = out_result_r;
  assign out_zero    = out_zero_r;
  assign out_illegal = out_illegal_r;
  assign op_count    = op_count_r;
  assign alu_dr1     = alu_dr1_r;
  assign alu_dr2     = alu_dr2_r;
  assign alu_ctrl    = alu_ctrl_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a behavioural ALU drives alu_result,
// a transaction-level reference model predicts every result, and a per-cycle
// compare process checks the DUT against it.
module tb_alu_issue_ctrl;

  localparam int DATA_W  = 32;
  localparam int FUNCT_W = 6;
  localparam int CNT_W   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [FUNCT_W-1:0] in_funct = 6'h0;
  logic [DATA_W-1:0] in_rs = 32'h0;
  logic [DATA_W-1:0] in_rt = 32'h0;
  logic [DATA_W-1:0] alu_dr1;
  logic [DATA_W-1:0] alu_dr2;
  logic [2:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_result;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_result;
  logic              out_zero;
  logic              out_illegal;
  logic [CNT_W-1:0]  op_count;

  always #5 clk = ~clk;

  alu_issue_ctrl #(
    .DATA_W (DATA_W),
    .FUNCT_W(FUNCT_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct   (in_funct),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .alu_dr1    (alu_dr1),
    .alu_dr2    (alu_dr2),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_illegal(out_illegal),
    .op_count   (op_count)
  );

  // The combinational ALU the controller drives
  always_comb begin
    case (alu_ctrl)
      3'b001:  alu_result = alu_dr1 + alu_dr2;
      3'b010:  alu_result = alu_dr1 - alu_dr2;
      3'b011:  alu_result = (alu_dr1 > alu_dr2) ? 32'd1 : 32'd0;
      3'b100:  alu_result = alu_dr1 & alu_dr2;
      3'b101:  alu_result = alu_dr1 | alu_dr2;
      3'b110:  alu_result = alu_dr1 ^ alu_dr2;
      3'b111:  alu_result = ~(alu_dr1 | alu_dr2);
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end

  typedef struct packed {
    logic [31:0] res;
    logic        ill;
  } exp_t;

  // What an R-type op must produce, straight from the instruction semantics
  function automatic exp_t ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.res = 32'd0;
    e.ill = 1'b0;
    case (f)
      6'h20, 6'h21: e.res = a + b;
      6'h22, 6'h23: e.res = a - b;
      6'h24:        e.res = a & b;
      6'h25:        e.res = a | b;
      6'h26:        e.res = a ^ b;
      6'h27:        e.res = ~(a | b);
      6'h2A:        e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B:        e.res = (a < b) ? 32'd1 : 32'd0;
      default:      e.ill = 1'b1;
    endcase
    return e;
  endfunction

  exp_t        exp_q[$];
  logic [15:0] mdl_count = 16'd0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on handshakes; a reset discards the in-flight op
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      mdl_count <= 16'd0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        mdl_count <= mdl_count + 16'd1;
      end
      if (in_valid && in_ready) exp_q.push_back(ref_op(in_funct, in_rs, in_rt));
    end
  end

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("op_count", 64'(op_count), 64'(mdl_count));
      chk("alu_ctrl_nonzero", 64'(alu_ctrl == 3'b000), 64'd0);
      chk("ready_valid_excl", 64'(in_ready & out_valid), 64'd0);
      if (out_valid) begin
        chk("outstanding", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
          chk("out_result", 64'(out_result), 64'(exp_q[0].res));
          chk("out_zero", 64'(out_zero), 64'(exp_q[0].res == 32'd0));
          chk("out_illegal", 64'(out_illegal), 64'(exp_q[0].ill));
        end
      end
    end
  end

  task automatic check_reset_values();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_zero", 64'(out_zero), 64'd1);
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_alu_dr1", 64'(alu_dr1), 64'd0);
    chk("rst_alu_dr2", 64'(alu_dr2), 64'd0);
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd1);
  endtask

  // One op from accept to consume; called and returning at a falling edge
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int hold, input bit use_lit, input logic [31:0] lit_res,
                       input logic lit_ill);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_funct  = f;
    in_rs     = a;
    in_rt     = b;
    out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    // inputs are free to change once accepted; in_valid must be ignored now
    in_valid  = 1'($urandom_range(0, 1));
    in_funct  = 6'($urandom);
    in_rs     = $urandom;
    in_rt     = $urandom;
    out_ready = 1'($urandom_range(0, 1));
    chk("exec_in_ready", 64'(in_ready), 64'd0);
    chk("exec_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("latency_out_valid", 64'(out_valid), 64'd1);
    if (use_lit) begin
      chk("lit_result", 64'(out_result), 64'(lit_res));
      chk("lit_zero", 64'(out_zero), 64'(lit_res == 32'd0));
      chk("lit_illegal", 64'(out_illegal), 64'(lit_ill));
    end
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("consume_out_valid", 64'(out_valid), 64'd0);
    chk("consume_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [5:0] legal_f [10] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
                               6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B};

  initial begin
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;

    repeat (2) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    @(negedge clk);

    // reset while an op sits in EXEC: discarded and not counted
    in_valid = 1'b1;
    in_funct = 6'h20;
    in_rs    = 32'd5;
    in_rt    = 32'd7;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_exec", 64'(in_ready), 64'd0);
    #1 rst_n = 1'b0;
    #1 check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_op_count", 64'(op_count), 64'd0);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // directed ops with hand-computed results
    do_op(6'h20, 32'd5,          32'd7,      0, 1'b1, 32'd12,         1'b0);
    do_op(6'h2A, 32'hFFFF_FFFF,  32'd1,      1, 1'b1, 32'd1,          1'b0);
    do_op(6'h2B, 32'hFFFF_FFFF,  32'd1,      0, 1'b1, 32'd0,          1'b0);
    do_op(6'h22, 32'h1234,       32'h1234,   2, 1'b1, 32'd0,          1'b0);
    do_op(6'h27, 32'd0,          32'd0,      0, 1'b1, 32'hFFFF_FFFF,  1'b0);
    do_op(6'h08, 32'd9,          32'd3,      1, 1'b1, 32'd0,          1'b1);
    do_op(6'h25, 32'hF0F0_0000,  32'h0F0F,  10, 1'b1, 32'hF0F0_0F0F,  1'b0);
    chk("directed_op_count", 64'(op_count), 64'd7);
    do_op(6'h2A, 32'd3,          32'hFFFF_FFFE, 0, 1'b1, 32'd0,       1'b0);
    do_op(6'h23, 32'd0,          32'd1,      0, 1'b1, 32'hFFFF_FFFF,  1'b0);

    // randomized ops checked by the model
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) == 0) f = 6'($urandom);
      else f = legal_f[$urandom_range(0, 9)];
      a = pick_val();
      b = ($urandom_range(0, 7) == 0) ? a : pick_val();
      do_op(f, a, b, $urandom_range(0, 3), 1'b0, 32'd0, 1'b0);
    end
    chk("final_op_count", 64'(op_count), 64'd209);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
